// File: rtl/ddr2_traffic_gen_if.sv
// Host-port bundle between the traffic generator (master) and the ddr2 controller (slave).
interface ddr2_traffic_gen_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 16
);
  logic [2:0]        cmd;
  logic [1:0]        sz;
  logic [2:0]        op;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addr;
  logic              fetching;
  logic              notfull;
  logic [6:0]        fillcount;
  logic              validout;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] raddr;

  modport master (
    output cmd, sz, op, din, addr, fetching,
    input  notfull, fillcount, validout, dout, raddr
  );

  modport slave (
    input  cmd, sz, op, din, addr, fetching,
    output notfull, fillcount, validout, dout, raddr
  );
endinterface

// File: rtl/ddr2_traffic_gen.sv
// Self-checking ddr2 host-port traffic generator: writes NUM_OPS pattern words, reads them back, checks returns.
// Optional macro TG_THROTTLE_EN: also hold off issue while FILLCOUNT >= FILL_HI.
module ddr2_traffic_gen #(
  parameter int unsigned        ADDR_W    = 25,
  parameter int unsigned        DATA_W    = 16,
  parameter int unsigned        NUM_OPS   = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter int unsigned        STRIDE    = 1,
  parameter logic [DATA_W-1:0]  SEED      = DATA_W'(16'hA5A5),
  parameter int unsigned        TIMEOUT   = 4096,
  parameter int unsigned        FILL_HI   = 56
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic                 i_ready,
  ddr2_traffic_gen_if.master   bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [15:0]          o_err_count,
  output logic [ADDR_W-1:0]    o_first_err_addr
);
  localparam int unsigned CNT_W = $clog2(NUM_OPS + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);
  localparam logic [CNT_W-1:0] ALL_OPS = CNT_W'(NUM_OPS);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_WR  = 3'b010;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_cmd;
  logic              r_valid;
  logic [DATA_W-1:0] r_din;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mode;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_rd_seen;
  logic [WD_W-1:0]   r_wdog;
  logic              r_err_seen;
  logic              r_busy, r_done, r_pass;
  logic [15:0]       r_err_count;
  logic [ADDR_W-1:0] r_first_err_addr;

  logic              w_issue_ok, w_accept, w_checking, w_ret, w_mismatch, w_rd_done, w_launch;
  logic [CNT_W-1:0]  w_rd_nxt;
  logic [15:0]       w_err_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  // Expected data depends only on the address, so out-of-order returns check cleanly.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic m);
    logic [15:0] mix;
    mix = {a[7:0], ~a[7:0]};
    return (m ? DATA_W'(mix) : a[DATA_W-1:0]) ^ SEED;
  endfunction

`ifdef TG_THROTTLE_EN
  assign w_issue_ok = bus.notfull && (bus.fillcount < 7'(FILL_HI));
`else
  logic w_unused_fill;
  assign w_unused_fill = ^bus.fillcount;
  assign w_issue_ok    = bus.notfull;
`endif

  always_comb begin
    w_accept   = r_valid && w_issue_ok;
    w_checking = (r_state == S_READ) || (r_state == S_DRAIN);
    w_ret      = w_checking && bus.validout;
    w_mismatch = w_ret && (bus.dout != pattern(bus.raddr, r_mode));
    w_rd_nxt   = r_rd_seen + CNT_W'(w_ret);
    w_err_nxt  = (w_mismatch && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1 : r_err_count;
    w_rd_done  = (w_rd_nxt == ALL_OPS);
    w_launch   = i_start && (((r_state == S_IDLE) && i_ready) || (r_state == S_DONE));
    w_addr_nxt = r_addr + ADDR_W'(STRIDE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_cmd            <= CMD_NOP;
      r_valid          <= 1'b0;
      r_din            <= '0;
      r_addr           <= '0;
      r_mode           <= 1'b0;
      r_idx            <= '0;
      r_rd_seen        <= '0;
      r_wdog           <= '0;
      r_err_seen       <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      if (w_checking) begin
        r_rd_seen   <= w_rd_nxt;
        r_err_count <= w_err_nxt;
        if (w_mismatch && !r_err_seen) begin
          r_err_seen       <= 1'b1;
          r_first_err_addr <= bus.raddr;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_launch) begin
            r_state          <= S_WRITE;
            r_mode           <= i_mode;
            r_cmd            <= CMD_WR;
            r_valid          <= 1'b1;
            r_addr           <= BASE_ADDR;
            r_din            <= pattern(BASE_ADDR, i_mode);
            r_idx            <= '0;
            r_rd_seen        <= '0;
            r_wdog           <= '0;
            r_err_seen       <= 1'b0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            if (r_idx == LAST_OP) begin
              r_state <= S_READ;
              r_idx   <= '0;
              r_addr  <= BASE_ADDR;
              r_cmd   <= CMD_RD;
            end else begin
              r_idx  <= r_idx + CNT_W'(1);
              r_addr <= w_addr_nxt;
              r_din  <= pattern(w_addr_nxt, r_mode);
            end
          end
        end
        S_READ: begin
          if (w_accept) begin
            if (r_idx == LAST_OP) begin
              r_state <= S_DRAIN;
              r_valid <= 1'b0;
              r_cmd   <= CMD_NOP;
              r_wdog  <= '0;
            end else begin
              r_idx  <= r_idx + CNT_W'(1);
              r_addr <= w_addr_nxt;
            end
          end
        end
        S_DRAIN: begin
          // Watchdog counts consecutive cycles without a return.
          if (w_rd_done) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == 16'd0);
          end else if (bus.validout) begin
            r_wdog <= '0;
          end else if (r_wdog == WD_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd          = r_cmd;
  assign bus.sz           = 2'b00;
  assign bus.op           = 3'b000;
  assign bus.din          = r_din;
  assign bus.addr         = r_addr;
  assign bus.fetching     = w_accept;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;
endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed bench for ddr2_traffic_gen with a behavioural host-port memory.
module tb_ddr2_traffic_gen;
  logic clk = 1'b0;
  logic rst, ready, start0, mode0, start1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, err1;
  logic [24:0] ferr0, ferr1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr2_traffic_gen_if #(.ADDR_W(25), .DATA_W(16)) bus0 ();
  ddr2_traffic_gen_if #(.ADDR_W(25), .DATA_W(16)) bus1 ();

  ddr2_traffic_gen #(.NUM_OPS(8), .TIMEOUT(64)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_start(start0), .i_mode(mode0), .i_ready(ready),
    .bus(bus0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(err0), .o_first_err_addr(ferr0));

  ddr2_traffic_gen #(.NUM_OPS(4), .BASE_ADDR(25'h1FFFFFE), .TIMEOUT(64)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .i_mode(1'b0), .i_ready(ready),
    .bus(bus1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
    .o_err_count(err1), .o_first_err_addr(ferr1));

  // Memory model for dut0: accept sampled mid-cycle, one return per cycle after accept.
  logic [15:0] mem [logic [24:0]];
  logic [24:0] rq[$];
  logic [24:0] wr_a[$];
  logic [15:0] wr_d[$];
  logic [24:0] rd_a[$];
  logic [24:0] w1_a[$];
  logic [15:0] w1_d[$];
  bit          drop_en = 1'b0, corrupt_en = 1'b0;
  logic [24:0] drop_a = '0, corrupt_a = '0;

  always begin : mem_model
    logic        m_acc;
    logic [2:0]  m_cmd;
    logic [24:0] m_addr, ra;
    logic [15:0] m_din;
    @(negedge clk);
    m_acc  = bus0.fetching && bus0.notfull && !rst;
    m_cmd  = bus0.cmd;
    m_addr = bus0.addr;
    m_din  = bus0.din;
    @(posedge clk);
    #1;
    if (m_acc && m_cmd == 3'b010) begin
      mem[m_addr] = m_din;
      wr_a.push_back(m_addr);
      wr_d.push_back(m_din);
    end else if (m_acc && m_cmd == 3'b001) begin
      rq.push_back(m_addr);
      rd_a.push_back(m_addr);
    end
    bus0.validout = 1'b0;
    if (rq.size() != 0) begin
      ra = rq.pop_front();
      if (!(drop_en && ra == drop_a)) begin
        bus0.validout = 1'b1;
        bus0.raddr    = ra;
        bus0.dout     = mem.exists(ra) ? mem[ra] : 16'h0000;
        if (corrupt_en && ra == corrupt_a) bus0.dout = bus0.dout ^ 16'h0001;
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.fetching && bus1.cmd == 3'b010 && !rst) begin
      w1_a.push_back(bus1.addr);
      w1_d.push_back(bus1.din);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done0(input int bound);
    int n = 0;
    while (done0 !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk("done0_reached", 32'(done0), 32'd1);
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); rd_a.delete();
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    logic [24:0] a_hold;
    logic [15:0] d_hold;
    bit          stable;
    int          n;
    rst = 1'b1; ready = 1'b0; start0 = 1'b0; mode0 = 1'b0; start1 = 1'b0;
    bus0.notfull = 1'b1; bus0.fillcount = 7'd0; bus0.validout = 1'b0;
    bus0.dout = '0; bus0.raddr = '0;
    bus1.notfull = 1'b1; bus1.fillcount = 7'd0; bus1.validout = 1'b0;
    bus1.dout = '0; bus1.raddr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset values
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_err", 32'(err0), 0);
    chk("rst_ferr", 32'(ferr0), 0);
    chk("rst_fetch", 32'(bus0.fetching), 0);
    chk("rst_cmd", 32'(bus0.cmd), 0);
    chk("rst_addr", 32'(bus0.addr), 0);
    chk("rst_din", 32'(bus0.din), 0);

    // START ignored while not ready
    pulse_start0();
    chk("start_not_ready_busy", 32'(busy0), 0);
    tick();
    chk("start_not_ready_fetch", 32'(bus0.fetching), 0);

    // Run 1: mode 0, ideal memory
    ready = 1'b1;
    clear_logs();
    pulse_start0();
    chk("run1_busy", 32'(busy0), 1);
    chk("run1_cmd", 32'(bus0.cmd), 32'h2);
    chk("run1_addr0", 32'(bus0.addr), 0);
    chk("run1_din0", 32'(bus0.din), 32'hA5A5);
    chk("run1_fetch", 32'(bus0.fetching), 1);
    chk("run1_sz_op", 32'({bus0.sz, bus0.op}), 0);
    wait_done0(200);
    chk("run1_nwr", 32'(wr_a.size()), 8);
    for (int k = 0; k < 8 && k < wr_a.size(); k++) begin
      chk("run1_wr_addr", 32'(wr_a[k]), 32'(k));
      chk("run1_wr_din", 32'(wr_d[k]), 32'(k) ^ 32'hA5A5);
    end
    chk("run1_nrd", 32'(rd_a.size()), 8);
    chk("run1_pass", 32'(pass0), 1);
    chk("run1_err", 32'(err0), 0);
    chk("run1_busy_end", 32'(busy0), 0);

    // Run 2: mode 1, address 3 return corrupted
    corrupt_en = 1'b1; corrupt_a = 25'd3; mode0 = 1'b1;
    clear_logs();
    pulse_start0();
    mode0 = 1'b0;
    chk("run2_done_cleared", 32'(done0), 0);
    wait_done0(200);
    chk("run2_din0", 32'(wr_d.size() > 0 ? wr_d[0] : 16'h0), 32'hA55A);
    chk("run2_din2", 32'(wr_d.size() > 2 ? wr_d[2] : 16'h0), 32'hA758);
    chk("run2_err", 32'(err0), 1);
    chk("run2_ferr", 32'(ferr0), 3);
    chk("run2_pass", 32'(pass0), 0);
    corrupt_en = 1'b0;

    // Run 3: NOTFULL low for 10 cycles mid-write
    clear_logs();
    pulse_start0();
    repeat (3) tick();
    bus0.notfull = 1'b0;
    a_hold = bus0.addr;
    d_hold = bus0.din;
    chk("run3_hold_addr", 32'(a_hold), 3);
    chk("run3_hold_din", 32'(d_hold), 32'hA5A6);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus0.addr !== a_hold || bus0.din !== d_hold || bus0.cmd !== 3'b010 || bus0.fetching !== 1'b0)
        stable = 1'b0;
    end
    chk("run3_stable", 32'(stable), 1);
    bus0.notfull = 1'b1;
    wait_done0(200);
    chk("run3_nwr", 32'(wr_a.size()), 8);
    for (int k = 0; k < 8 && k < wr_a.size(); k++)
      chk("run3_wr_addr", 32'(wr_a[k]), 32'(k));
    chk("run3_pass", 32'(pass0), 1);

    // Run 4: final read return dropped -> watchdog
    drop_en = 1'b1; drop_a = 25'd7;
    clear_logs();
    pulse_start0();
    n = 0;
    while (rd_a.size() < 8 && n < 100) begin tick(); n++; end
    tick();
    chk("run4_not_early", 32'(done0), 0);
    wait_done0(300);
    chk("run4_pass", 32'(pass0), 0);
    chk("run4_err", 32'(err0), 0);
    drop_en = 1'b0;

    // Run 5: FILLCOUNT at threshold
    clear_logs();
    pulse_start0();
    repeat (2) tick();
    bus0.fillcount = 7'd56;
    repeat (3) tick();
`ifdef TG_THROTTLE_EN
    chk("run5_throttle_fetch", 32'(bus0.fetching), 0);
    chk("run5_throttle_addr", 32'(bus0.addr), 2);
`else
    chk("run5_nothrottle_fetch", 32'(bus0.fetching), 1);
    chk("run5_nothrottle_addr", 32'(bus0.addr), 5);
`endif
    bus0.fillcount = 7'd55;
    tick();
    chk("run5_resume_fetch", 32'(bus0.fetching), 1);
    bus0.fillcount = 7'd0;
    wait_done0(200);
    chk("run5_nwr", 32'(wr_a.size()), 8);
    chk("run5_pass", 32'(pass0), 1);

    // Run 6: reset mid-read
    clear_logs();
    pulse_start0();
    n = 0;
    while (bus0.cmd !== 3'b001 && n < 50) begin tick(); n++; end
    chk("run6_in_read", 32'(bus0.cmd), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("run6_rst_busy", 32'(busy0), 0);
    chk("run6_rst_fetch", 32'(bus0.fetching), 0);
    chk("run6_rst_cmd", 32'(bus0.cmd), 0);
    chk("run6_rst_addr", 32'(bus0.addr), 0);
    chk("run6_rst_din", 32'(bus0.din), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("run6_idle_busy", 32'(busy0), 0);
    chk("run6_idle_done", 32'(done0), 0);
    chk("run6_idle_err", 32'(err0), 0);
    chk("run6_idle_ferr", 32'(ferr0), 0);

    // Address wrap on dut1 (no returns, so it times out)
    w1_a.delete(); w1_d.delete();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 300) begin tick(); n++; end
    chk("wrap_done", 32'(done1), 1);
    chk("wrap_nwr", 32'(w1_a.size()), 4);
    if (w1_a.size() == 4) begin
      chk("wrap_a0", 32'(w1_a[0]), 32'h1FFFFFE);
      chk("wrap_a1", 32'(w1_a[1]), 32'h1FFFFFF);
      chk("wrap_a2", 32'(w1_a[2]), 32'h0);
      chk("wrap_a3", 32'(w1_a[3]), 32'h1);
      chk("wrap_d0", 32'(w1_d[0]), 32'h5A5B);
      chk("wrap_d2", 32'(w1_d[2]), 32'hA5A5);
    end
    chk("wrap_pass", 32'(pass1), 0);
    chk("wrap_err", 32'(err1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
